// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM->WB pipeline stage: writeback control layout
// and the beat carried from the memory stage to the writeback stage.
package mem_wb_pkg;

  localparam int WB_CTRL_W         = 2;
  localparam int WB_REG_WRITE_BIT  = 0;
  localparam int WB_MEM_TO_REG_BIT = 1;

  typedef struct packed {
    logic [WB_CTRL_W-1:0] wb;
    logic [31:0]          read_data;
    logic [31:0]          alu_result;
    logic [4:0]           write_reg;
  } mem_wb_beat_t;

endpackage

// File: rtl/mem_wb_store.sv
// DEPTH x W storage for the MEM->WB buffer: one write port, one asynchronous
// read port. Holds data only; occupancy control lives in the parent.
module mem_wb_store #(
  parameter int W     = 71,
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // No reset on the array: only the parent's pointers/count define validity.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_wb_pipe.sv
// Elastic MEM->WB stage: a DEPTH-entry FIFO of writeback beats with flush and
// occupancy output. Beats move on valid & ready at the rising edge.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int CTRL_W = WB_CTRL_W,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_wb,
  input  logic [DATA_W-1:0]          in_read_data,
  input  logic [DATA_W-1:0]          in_alu_result,
  input  logic [REG_W-1:0]           in_write_reg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_wb,
  output logic [DATA_W-1:0]          out_read_data,
  output logic [DATA_W-1:0]          out_alu_result,
  output logic [REG_W-1:0]           out_write_reg,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int BEAT_W  = CTRL_W + 2 * DATA_W + REG_W;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [COUNT_W-1:0] r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [BEAT_W-1:0]  w_wr_beat;
  logic [BEAT_W-1:0]  w_rd_beat;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: a beat transfers on a rising edge where valid & ready & !flush.
  // in_ready / out_valid come from r_count only, so a pop while full never
  // frees a slot for a push in the same cycle.
  assign w_in_ready  = (r_count < COUNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & w_in_ready & ~flush;
  assign w_pop       = w_out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_wr_beat = {in_wb, in_read_data, in_alu_result, in_write_reg};

  mem_wb_store #(
    .W     (BEAT_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_store (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (w_wr_beat),
    .i_raddr (r_head),
    .o_rdata (w_rd_beat)
  );

  // Gate control so an empty stage can never trigger a register-file write.
  assign out_wb         = w_out_valid ? w_rd_beat[BEAT_W-1 -: CTRL_W] : '0;
  assign out_read_data  = w_rd_beat[REG_W + 2*DATA_W - 1 -: DATA_W];
  assign out_alu_result = w_rd_beat[REG_W + DATA_W - 1 -: DATA_W];
  assign out_write_reg  = w_rd_beat[REG_W-1:0];
  assign in_ready       = w_in_ready;
  assign out_valid      = w_out_valid;
  assign count          = r_count;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus random traffic,
// checked against a queue-based model of the buffer contents.
module tb_mem_wb_pipe;
  import mem_wb_pkg::*;

  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH+1);
  localparam int BEAT_W = $bits(mem_wb_beat_t);

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_wb;
  logic [31:0]   in_read_data;
  logic [31:0]   in_alu_result;
  logic [4:0]    in_write_reg;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_wb;
  logic [31:0]   out_read_data;
  logic [31:0]   out_alu_result;
  logic [4:0]    out_write_reg;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [BEAT_W-1:0] exp_q[$];

  mem_wb_pipe #(
    .CTRL_W (2),
    .DATA_W (32),
    .REG_W  (5),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wb          (in_wb),
    .in_read_data   (in_read_data),
    .in_alu_result  (in_alu_result),
    .in_write_reg   (in_write_reg),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wb         (out_wb),
    .out_read_data  (out_read_data),
    .out_alu_result (out_alu_result),
    .out_write_reg  (out_write_reg),
    .count          (count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mem_wb_beat_t rand_beat();
    mem_wb_beat_t b;
    b.wb         = 2'($urandom_range(0, 3));
    b.read_data  = $urandom;
    b.alu_result = $urandom;
    b.write_reg  = 5'($urandom_range(0, 31));
    return b;
  endfunction

  function automatic mem_wb_beat_t mk_beat(input logic [1:0] wb, input logic [31:0] rd,
                                           input logic [31:0] alu, input logic [4:0] rg);
    mem_wb_beat_t b;
    b.wb = wb; b.read_data = rd; b.alu_result = alu; b.write_reg = rg;
    return b;
  endfunction

  // scoreboard: compare every observable output with the model queue
  task automatic check_outputs(input string tag);
    mem_wb_beat_t h;
    check_eq({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(exp_q.size() < DEPTH));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check_eq({tag, ".wb"}, 64'(out_wb), 64'(h.wb));
      check_eq({tag, ".rd"}, 64'(out_read_data), 64'(h.read_data));
      check_eq({tag, ".alu"}, 64'(out_alu_result), 64'(h.alu_result));
      check_eq({tag, ".reg"}, 64'(out_write_reg), 64'(h.write_reg));
    end else begin
      check_eq({tag, ".wb_gated"}, 64'(out_wb), 64'd0);
    end
  endtask

  // driver: present inputs for one cycle, advance the model at the edge, check
  task automatic step(input string tag, input logic v, input logic rdy, input logic fl,
                      input mem_wb_beat_t b);
    logic accept;
    in_valid      = v;
    out_ready     = rdy;
    flush         = fl;
    in_wb         = b.wb;
    in_read_data  = b.read_data;
    in_alu_result = b.alu_result;
    in_write_reg  = b.write_reg;
    accept = v && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (accept) exp_q.push_back(b);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_wb = '0; in_read_data = '0; in_alu_result = '0; in_write_reg = '0;
  endtask

  initial begin
    mem_wb_beat_t a, b;
    rst = 1'b1;
    idle_inputs();
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // single beat
    a = mk_beat(2'b11, 32'hDEAD_BEEF, 32'h10, 5'd7);
    step("single_push", 1'b1, 1'b0, 1'b0, a);
    check_eq("single_rd", 64'(out_read_data), 64'h0000_0000_DEAD_BEEF);
    check_eq("single_reg", 64'(out_write_reg), 64'd7);
    step("single_pop", 1'b0, 1'b1, 1'b0, rand_beat());
    check_eq("single_empty", 64'(count), 64'd0);

    // fill / backpressure
    step("fill_a", 1'b1, 1'b0, 1'b0, mk_beat(2'b01, 32'hA, 32'hA0, 5'd1));
    step("fill_b", 1'b1, 1'b0, 1'b0, mk_beat(2'b10, 32'hB, 32'hB0, 5'd2));
    check_eq("fill_ready_low", 64'(in_ready), 64'd0);
    step("fill_c", 1'b1, 1'b0, 1'b0, mk_beat(2'b11, 32'hC, 32'hC0, 5'd3));
    check_eq("fill_c_refused", 64'(count), 64'd2);
    check_eq("drain_first_a", 64'(out_write_reg), 64'd1);
    step("drain_a", 1'b0, 1'b1, 1'b0, rand_beat());
    check_eq("drain_second_b", 64'(out_write_reg), 64'd2);
    step("drain_b", 1'b0, 1'b1, 1'b0, rand_beat());

    // streaming
    for (int i = 0; i < 100; i++) begin
      b = rand_beat();
      b.write_reg = 5'(i);
      step("stream", 1'b1, 1'b1, 1'b0, b);
      check_eq("stream_count_le1", 64'(count <= CW'(1)), 64'd1);
      check_eq("stream_no_bubble", 64'(out_valid), 64'd1);
    end
    step("stream_drain", 1'b0, 1'b1, 1'b0, rand_beat());

    // flush with concurrent input beat
    step("fl_fill0", 1'b1, 1'b0, 1'b0, rand_beat());
    step("fl_fill1", 1'b1, 1'b0, 1'b0, rand_beat());
    step("flush", 1'b1, 1'b1, 1'b1, mk_beat(2'b11, 32'hF1, 32'hF2, 5'd31));
    check_eq("flush_count", 64'(count), 64'd0);
    step("post_flush", 1'b0, 1'b1, 1'b0, rand_beat());
    check_eq("flush_beat_gone", 64'(out_valid), 64'd0);

    // full push+pop: pop happens, push refused
    step("fp_fill0", 1'b1, 1'b0, 1'b0, rand_beat());
    step("fp_fill1", 1'b1, 1'b0, 1'b0, rand_beat());
    step("full_pushpop", 1'b1, 1'b1, 1'b0, mk_beat(2'b01, 32'h55, 32'h66, 5'd9));
    check_eq("full_pushpop_count", 64'(count), 64'd1);
    step("retry_push", 1'b1, 1'b0, 1'b0, mk_beat(2'b01, 32'h55, 32'h66, 5'd9));
    check_eq("retry_count", 64'(count), 64'd2);
    step("fp_drain0", 1'b0, 1'b1, 1'b0, rand_beat());
    step("fp_drain1", 1'b0, 1'b1, 1'b0, rand_beat());

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0), rand_beat());
    end

    // asynchronous reset mid-traffic
    step("pre_rst0", 1'b1, 1'b0, 1'b0, rand_beat());
    step("pre_rst1", 1'b1, 1'b0, 1'b0, rand_beat());
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    a = rand_beat();
    step("post_rst_push", 1'b1, 1'b0, 1'b0, a);
    check_eq("post_rst_accepted", 64'(count), 64'd1);
    step("post_rst_pop", 1'b0, 1'b1, 1'b0, rand_beat());

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
